// File: rtl/sdr_cfg_pkg.sv
// Shared types and constants for the SDRAM configuration sequencer.
package sdr_cfg_pkg;

    // Sequencer states; encodings are visible in STATUS[6:4].
    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_LOAD      = 3'd1,
        ST_INIT_WAIT = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_QUIET     = 3'd5,
        ST_FAULT     = 3'd6
    } state_e;

    // Register indices.
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_MODE   = 3'd2;
    localparam logic [2:0] REG_TIM    = 3'd3;
    localparam logic [2:0] REG_GEOM   = 3'd4;
    localparam logic [2:0] REG_RFSH   = 3'd5;

    // Reset defaults for the shadow and active banks.
    localparam logic [1:0]  RST_WIDTH     = 2'b10;
    localparam logic [1:0]  RST_COLBITS   = 2'd0;
    localparam logic [1:0]  RST_REQ_DEPTH = 2'd3;
    localparam logic [3:0]  RST_TRAS      = 4'd4;
    localparam logic [3:0]  RST_TRP       = 4'd2;
    localparam logic [3:0]  RST_TRCD      = 4'd2;
    localparam logic [3:0]  RST_TRCAR     = 4'd7;
    localparam logic [3:0]  RST_TWR       = 4'd1;
    localparam logic [2:0]  RST_CAS       = 3'd3;
    localparam logic [12:0] RST_MODE      = 13'h033;
    localparam logic [15:0] RST_RFSH      = 16'h0100;
    localparam logic [15:0] RST_RFMAX     = 16'h0006;

    // One complete configuration set. Refresh fields are held at their
    // maximum register-field width (16 bits) and masked to the configured
    // width on write, so any parameterisation fits the same struct.
    typedef struct packed {
        logic [1:0]  width;
        logic [1:0]  colbits;
        logic [1:0]  req_depth;
        logic [3:0]  tras;
        logic [3:0]  trp;
        logic [3:0]  trcd;
        logic [3:0]  trcar;
        logic [3:0]  twr;
        logic [2:0]  cas;
        logic [12:0] mode;
        logic [15:0] rfsh;
        logic [15:0] rfmax;
    } sdr_cfg_t;

    localparam sdr_cfg_t CFG_RESET = '{
        width:     RST_WIDTH,
        colbits:   RST_COLBITS,
        req_depth: RST_REQ_DEPTH,
        tras:      RST_TRAS,
        trp:       RST_TRP,
        trcd:      RST_TRCD,
        trcar:     RST_TRCAR,
        twr:       RST_TWR,
        cas:       RST_CAS,
        mode:      RST_MODE,
        rfsh:      RST_RFSH,
        rfmax:     RST_RFMAX
    };

endpackage

// File: rtl/sdr_cfg_sequencer_regfile.sv
// Register bus front end: decode, ack, shadow bank, CTRL and STATUS fields.
module sdr_cfg_sequencer_regfile
    import sdr_cfg_pkg::*;
#(
    parameter int SDR_REFRESH_TIMER_W   = 12,
    parameter int SDR_REFRESH_ROW_CNT_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_req,
    input  logic        reg_we,
    input  logic [2:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic        reg_ack,
    output logic [31:0] reg_rdata,
    input  logic        sdr_init_done,
    input  state_e      state,
    input  logic        fault_set,
    output sdr_cfg_t    shadow,
    output logic        en_eff,
    output logic        commit_pulse,
    output logic        fault
);

    localparam logic [15:0] RFSH_MASK  = 16'((1 << SDR_REFRESH_TIMER_W) - 1);
    localparam logic [15:0] RFMAX_MASK = 16'((1 << SDR_REFRESH_ROW_CNT_W) - 1);

    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    sdr_cfg_t    shadow_q, shadow_d;
    logic        en_q, en_d;
    logic        fault_q, fault_d;
    logic        acc_fire, wr_fire, rd_fire, ctrl_wr;

    // A request is accepted only when no ack is in flight, so every access takes two cycles.
    assign acc_fire = reg_req && !ack_q;
    assign wr_fire  = acc_fire && reg_we;
    assign rd_fire  = acc_fire && !reg_we;
    assign ctrl_wr  = wr_fire && (reg_addr == REG_CTRL);

    // EN as the sequencer must see it this cycle, so an EN=0 write takes effect immediately.
    assign en_eff       = ctrl_wr ? reg_wdata[0] : en_q;
    assign commit_pulse = ctrl_wr && reg_wdata[1];

    // Bus decode: read mux, shadow updates, EN and the sticky FAULT flag.
    always_comb begin
        ack_d    = acc_fire;
        rdata_d  = '0;
        shadow_d = shadow_q;
        en_d     = en_q;
        fault_d  = fault_q;
        if (rd_fire) begin
            case (reg_addr)
                REG_CTRL: rdata_d[0] = en_q;
                REG_STATUS: begin
                    rdata_d[0]   = sdr_init_done;
                    rdata_d[1]   = (state != ST_RUN);
                    rdata_d[2]   = fault_q;
                    rdata_d[6:4] = state;
                end
                REG_MODE: rdata_d[12:0] = shadow_q.mode;
                REG_TIM: begin
                    rdata_d[3:0]   = shadow_q.tras;
                    rdata_d[7:4]   = shadow_q.trp;
                    rdata_d[11:8]  = shadow_q.trcd;
                    rdata_d[15:12] = shadow_q.trcar;
                    rdata_d[19:16] = shadow_q.twr;
                    rdata_d[22:20] = shadow_q.cas;
                end
                REG_GEOM: begin
                    rdata_d[1:0] = shadow_q.width;
                    rdata_d[3:2] = shadow_q.colbits;
                    rdata_d[5:4] = shadow_q.req_depth;
                end
                REG_RFSH: begin
                    rdata_d[15:0]  = shadow_q.rfsh;
                    rdata_d[31:16] = shadow_q.rfmax;
                end
                default: rdata_d = '0;
            endcase
        end
        if (wr_fire) begin
            case (reg_addr)
                REG_CTRL:   en_d = reg_wdata[0];
                REG_STATUS: if (reg_wdata[2]) fault_d = 1'b0;
                REG_MODE:   shadow_d.mode = reg_wdata[12:0];
                REG_TIM: begin
                    shadow_d.tras  = reg_wdata[3:0];
                    shadow_d.trp   = reg_wdata[7:4];
                    shadow_d.trcd  = reg_wdata[11:8];
                    shadow_d.trcar = reg_wdata[15:12];
                    shadow_d.twr   = reg_wdata[19:16];
                    shadow_d.cas   = reg_wdata[22:20];
                end
                REG_GEOM: begin
                    shadow_d.width     = reg_wdata[1:0];
                    shadow_d.colbits   = reg_wdata[3:2];
                    shadow_d.req_depth = reg_wdata[5:4];
                end
                REG_RFSH: begin
                    shadow_d.rfsh  = reg_wdata[15:0] & RFSH_MASK;
                    shadow_d.rfmax = reg_wdata[31:16] & RFMAX_MASK;
                end
                default: ;
            endcase
        end
        // A timeout in the same cycle as a clear keeps the flag set.
        if (fault_set) fault_d = 1'b1;
    end

    // Register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            shadow_q <= CFG_RESET;
            en_q     <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            shadow_q <= shadow_d;
            en_q     <= en_d;
            fault_q  <= fault_d;
        end
    end

    assign reg_ack   = ack_q;
    assign reg_rdata = rdata_q;
    assign shadow    = shadow_q;
    assign fault     = fault_q;

endmodule

// File: rtl/sdr_cfg_sequencer.sv
// Configuration sequencer: moves shadow settings onto the active cfg bus only while the controller is disabled.
module sdr_cfg_sequencer
    import sdr_cfg_pkg::*;
#(
    parameter int SDR_REFRESH_TIMER_W   = 12,
    parameter int SDR_REFRESH_ROW_CNT_W = 3,
    parameter int INIT_TIMEOUT          = 50000,
    parameter int QUIET_CYCLES          = 8
) (
    input  logic                             sdram_clk,
    input  logic                             sdram_rst,
    input  logic                             reg_req,
    input  logic                             reg_we,
    input  logic [2:0]                       reg_addr,
    input  logic [31:0]                      reg_wdata,
    output logic                             reg_ack,
    output logic [31:0]                      reg_rdata,
    input  logic                             sdr_init_done,
    input  logic                             ctrl_idle,
    output logic                             cfg_hold,
    output logic                             cfg_fault,
    output logic [1:0]                       cfg_sdr_width,
    output logic [1:0]                       cfg_sdr_colbits,
    output logic [1:0]                       cfg_sdr_req_depth,
    output logic [3:0]                       cfg_sdr_tras_d,
    output logic [3:0]                       cfg_sdr_trp_d,
    output logic [3:0]                       cfg_sdr_trcd_d,
    output logic [3:0]                       cfg_sdr_trcar_d,
    output logic [3:0]                       cfg_sdr_twr_d,
    output logic [2:0]                       cfg_sdr_cas,
    output logic [12:0]                      cfg_sdr_mode_reg,
    output logic [SDR_REFRESH_TIMER_W-1:0]   cfg_sdr_rfsh,
    output logic [SDR_REFRESH_ROW_CNT_W-1:0] cfg_sdr_rfmax,
    output logic                             cfg_sdr_en
);

    localparam int             TW         = $clog2(INIT_TIMEOUT + QUIET_CYCLES + 1);
    localparam logic [TW-1:0]  INIT_LAST  = TW'(INIT_TIMEOUT - 1);
    localparam logic [TW-1:0]  QUIET_LAST = TW'(QUIET_CYCLES - 1);

    state_e         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           commit_pend_q, commit_pend_d;
    sdr_cfg_t       active_q, active_d;
    sdr_cfg_t       shadow;
    logic           en_eff, commit_pulse, fault_set;
    logic           unused_active;

    sdr_cfg_sequencer_regfile #(
        .SDR_REFRESH_TIMER_W  (SDR_REFRESH_TIMER_W),
        .SDR_REFRESH_ROW_CNT_W(SDR_REFRESH_ROW_CNT_W)
    ) u_regfile (
        .clk          (sdram_clk),
        .rst          (sdram_rst),
        .reg_req      (reg_req),
        .reg_we       (reg_we),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_ack      (reg_ack),
        .reg_rdata    (reg_rdata),
        .sdr_init_done(sdr_init_done),
        .state        (state_q),
        .fault_set    (fault_set),
        .shadow       (shadow),
        .en_eff       (en_eff),
        .commit_pulse (commit_pulse),
        .fault        (cfg_fault)
    );

    // Next-state, timer, pending-commit and active-bank update logic.
    always_comb begin
        state_d       = state_q;
        timer_d       = '0;
        commit_pend_d = commit_pend_q;
        active_d      = active_q;
        fault_set     = 1'b0;
        case (state_q)
            ST_OFF: if (en_eff) state_d = ST_LOAD;
            ST_LOAD: begin
                active_d      = shadow;
                commit_pend_d = 1'b0;
                state_d       = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (!en_eff) begin
                    state_d = ST_QUIET;
                end else if (sdr_init_done) begin
                    state_d = ST_RUN;
                end else if (timer_q == INIT_LAST) begin
                    state_d   = ST_FAULT;
                    fault_set = 1'b1;
                end
            end
            ST_RUN:   if (!en_eff || commit_pend_q) state_d = ST_DRAIN;
            ST_DRAIN: if (ctrl_idle) state_d = ST_QUIET;
            ST_QUIET: if (timer_q == QUIET_LAST) state_d = en_eff ? ST_LOAD : ST_OFF;
            ST_FAULT: begin
                if (!en_eff) begin
                    state_d = ST_OFF;
                end else if (commit_pulse) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_OFF;
        endcase
        // A commit landing during LOAD arrived after the snapshot, so it stays pending.
        if (commit_pulse && (state_q != ST_OFF)) commit_pend_d = 1'b1;
        // The timer restarts on every state entry and only counts where it is consulted.
        if ((state_d == state_q) && ((state_q == ST_INIT_WAIT) || (state_q == ST_QUIET))) begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Sequencer state, timer and active bank registers.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_q       <= ST_OFF;
            timer_q       <= '0;
            commit_pend_q <= 1'b0;
            active_q      <= CFG_RESET;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            commit_pend_q <= commit_pend_d;
            active_q      <= active_d;
        end
    end

    assign cfg_sdr_en = (state_q == ST_INIT_WAIT) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign cfg_hold   = (state_q != ST_RUN);

    assign cfg_sdr_width     = active_q.width;
    assign cfg_sdr_colbits   = active_q.colbits;
    assign cfg_sdr_req_depth = active_q.req_depth;
    assign cfg_sdr_tras_d    = active_q.tras;
    assign cfg_sdr_trp_d     = active_q.trp;
    assign cfg_sdr_trcd_d    = active_q.trcd;
    assign cfg_sdr_trcar_d   = active_q.trcar;
    assign cfg_sdr_twr_d     = active_q.twr;
    assign cfg_sdr_cas       = active_q.cas;
    assign cfg_sdr_mode_reg  = active_q.mode;
    assign cfg_sdr_rfsh      = active_q.rfsh[SDR_REFRESH_TIMER_W-1:0];
    assign cfg_sdr_rfmax     = active_q.rfmax[SDR_REFRESH_ROW_CNT_W-1:0];

    // Upper refresh bits are always zero after masking on write.
    assign unused_active = ^{active_q.rfsh, active_q.rfmax};

endmodule
